// File: rtl/bn_ctrl.sv
// Purpose : batch-norm sequencer; counts accumulator beats per channel/pixel, issues BN param reads, pipelines valid/data to bn_unit.
// Latency : beat at t -> rd_en/rd_addr at t, fout_result_valid/data/param a at t+1, param b at t+2, bn_result_valid at t+3.
// Backpressure: none; one beat per cycle is accepted in RUN, beats outside RUN are dropped.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   layer_start, cfg_*                  layer kick-off; config latched only when IDLE
//   fout_valid_in, fout_data_in         accumulator beats, channel-innermost order
//   bnbuf_rd_en/addr, bnbuf_rd_data_a/b BN parameter buffer read port (1-cycle latency)
//   fout_result_valid, bn_input_data,
//   bn_param_data_a/b, bn_enable_layer  feed to bn_unit
//   bn_result_valid                     bn_unit output valid (2 cycles after fout_result_valid)
//   busy, layer_done                    layer status

`ifndef PARAM_BNBUF_DATA_WIDTH
`define PARAM_BNBUF_DATA_WIDTH 16
`endif

module bn_ctrl #(
  parameter int BN_DATA_WIDTH    = `PARAM_BNBUF_DATA_WIDTH,
  parameter int BNBUF_ADDR_WIDTH = 10,
  parameter int PIX_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        layer_start,
  input  logic                        cfg_bn_enable,
  input  logic [BNBUF_ADDR_WIDTH:0]   cfg_oc_num,
  input  logic [PIX_CNT_WIDTH-1:0]    cfg_pix_num,
  input  logic                        fout_valid_in,
  input  logic [BN_DATA_WIDTH-1:0]    fout_data_in,
  output logic                        bnbuf_rd_en,
  output logic [BNBUF_ADDR_WIDTH-1:0] bnbuf_rd_addr,
  input  logic [BN_DATA_WIDTH-1:0]    bnbuf_rd_data_a,
  input  logic [BN_DATA_WIDTH-1:0]    bnbuf_rd_data_b,
  output logic                        fout_result_valid,
  output logic [BN_DATA_WIDTH-1:0]    bn_input_data,
  output logic [BN_DATA_WIDTH-1:0]    bn_param_data_a,
  output logic [BN_DATA_WIDTH-1:0]    bn_param_data_b,
  output logic                        bn_enable_layer,
  output logic                        bn_result_valid,
  output logic                        busy,
  output logic                        layer_done
);

  localparam logic [BNBUF_ADDR_WIDTH:0]   OC_ONE  = 1;
  localparam logic [BNBUF_ADDR_WIDTH-1:0] CH_ONE  = 1;
  localparam logic [PIX_CNT_WIDTH-1:0]    PIX_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [1:0]                  r_drain_cnt;
  logic                        r_bn_en;
  logic [BNBUF_ADDR_WIDTH:0]   r_oc_num;
  logic [PIX_CNT_WIDTH-1:0]    r_pix_num;
  logic [BNBUF_ADDR_WIDTH-1:0] r_ch_cnt;
  logic [PIX_CNT_WIDTH-1:0]    r_pix_cnt;
  logic                        r_frv;
  logic [BN_DATA_WIDTH-1:0]    r_data;
  logic [BN_DATA_WIDTH-1:0]    r_param_b;
  logic                        r_vld_d1;
  logic                        r_vld_d2;

  logic w_start;
  logic w_cfg_empty;
  logic w_accept;
  logic w_ch_last;
  logic w_pix_last;
  logic w_final;
  logic w_layer_done;

  assign w_start     = layer_start && (r_state == S_IDLE);
  assign w_cfg_empty = (cfg_oc_num == '0) || (cfg_pix_num == '0);
  assign w_accept    = (r_state == S_RUN) && fout_valid_in;
  // Channel counter is one bit narrower than cfg_oc_num, so extend before comparing.
  assign w_ch_last   = ({1'b0, r_ch_cnt} == (r_oc_num - OC_ONE));
  assign w_pix_last  = (r_pix_cnt == (r_pix_num - PIX_ONE));
  assign w_final     = w_accept && w_ch_last && w_pix_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + 2'd1) : 2'd0;
    end
  end

  // Next state; layer_done fires on the third DRAIN cycle, which lines up
  // with the final beat's bn_result_valid.
  always_comb begin
    w_state_nxt  = r_state;
    w_layer_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (layer_start) w_state_nxt = w_cfg_empty ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (w_final) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == 2'd2) begin
          w_state_nxt  = S_IDLE;
          w_layer_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch and channel/pixel counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bn_en   <= 1'b0;
      r_oc_num  <= '0;
      r_pix_num <= '0;
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
    end else if (w_start) begin
      r_bn_en   <= cfg_bn_enable;
      r_oc_num  <= cfg_oc_num;
      r_pix_num <= cfg_pix_num;
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      if (w_ch_last) begin
        r_ch_cnt  <= '0;
        r_pix_cnt <= r_pix_cnt + PIX_ONE;
      end else begin
        r_ch_cnt  <= r_ch_cnt + CH_ONE;
      end
    end
  end

  // Datapath pipeline: stage 1 lines data up with param a from the buffer,
  // param b is held one more cycle to meet the second BN stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frv     <= 1'b0;
      r_data    <= '0;
      r_param_b <= '0;
      r_vld_d1  <= 1'b0;
      r_vld_d2  <= 1'b0;
    end else begin
      r_frv     <= w_accept;
      if (w_accept) r_data <= fout_data_in;
      r_param_b <= bnbuf_rd_data_b;
      r_vld_d1  <= r_frv;
      r_vld_d2  <= r_vld_d1;
    end
  end

  assign bnbuf_rd_en       = w_accept && r_bn_en;
  assign bnbuf_rd_addr     = r_ch_cnt;
  assign fout_result_valid = r_frv;
  assign bn_input_data     = r_data;
  assign bn_param_data_a   = bnbuf_rd_data_a;
  assign bn_param_data_b   = r_param_b;
  assign bn_enable_layer   = r_bn_en;
  assign bn_result_valid   = r_vld_d2;
  assign busy              = (r_state != S_IDLE);
  assign layer_done        = w_layer_done;

endmodule
